// File: rtl/twofish_sbox_key_gen.sv
// rtl/twofish_sbox_key_gen.sv - iterative Twofish RS(4x8) key-to-S-box word generator
// Folds one key byte per clock into S0 (m0..m7) or S1 (m8..m15) over GF(2^8).
module twofish_sbox_key_gen #(
  parameter logic [7:0] RS_POLY = 8'h4D
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [127:0] key_i,
  input  logic         key_valid_i,
  output logic         key_ready_o,
  output logic [31:0]  s0_o,
  output logic [31:0]  s1_o,
  output logic         out_valid_o,
  input  logic         out_ready_i
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [127:0]  key_q, key_d;
  logic [31:0]   s0_q, s0_d;
  logic [31:0]   s1_q, s1_d;
  logic [7:0]    m_byte;
  logic [6:0]    byte_base;
  logic [31:0]   col;
  logic [31:0]   prod;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ RS_POLY) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [31:0] rs_col(input logic [2:0] idx);
    case (idx)
      3'd0:    return 32'h01A402A4;
      3'd1:    return 32'hA456A155;
      3'd2:    return 32'h5582FC87;
      3'd3:    return 32'h87F3C15A;
      3'd4:    return 32'h5A1E4758;
      3'd5:    return 32'h58C6AEDB;
      3'd6:    return 32'hDB683D9E;
      default: return 32'h9EE51903;
    endcase
  endfunction

  // m0 lives in the top byte, so byte cnt starts at bit 8*(15-cnt)
  assign byte_base = {~cnt_q, 3'b000};
  assign m_byte    = key_q[byte_base +: 8];
  assign col       = rs_col(cnt_q[2:0]);
  assign prod      = {gf_mul(col[31:24], m_byte), gf_mul(col[23:16], m_byte),
                      gf_mul(col[15:8], m_byte),  gf_mul(col[7:0], m_byte)};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    case (state_q)
      IDLE: begin
        if (key_valid_i) begin
          key_d   = key_i;
          s0_d    = 32'h0;
          s1_d    = 32'h0;
          cnt_d   = 4'd0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (cnt_q[3]) s1_d = s1_q ^ prod;
        else          s0_d = s0_q ^ prod;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = DONE;
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      key_q   <= 128'h0;
      s0_q    <= 32'h0;
      s1_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
    end
  end

  assign key_ready_o = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign s0_o        = s0_q;
  assign s1_o        = s1_q;

endmodule

// File: tb/tb_twofish_sbox_key_gen.sv
// tb/tb_twofish_sbox_key_gen.sv - scoreboard bench for twofish_sbox_key_gen
// Expected S-box words come from a matrix model using carry-less multiply and polynomial reduction.
module tb_twofish_sbox_key_gen;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [127:0] key_i;
  logic         key_valid_i;
  logic         key_ready_o;
  logic [31:0]  s0_o;
  logic [31:0]  s1_o;
  logic         out_valid_o;
  logic         out_ready_i;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic [63:0] exp_q[$];
  int          acc_q[$];
  bit          prev_ov = 1'b0;

  localparam logic [31:0] RS_COLS [8] = '{32'h01A402A4, 32'hA456A155, 32'h5582FC87, 32'h87F3C15A,
                                          32'h5A1E4758, 32'h58C6AEDB, 32'hDB683D9E, 32'h9EE51903};

  twofish_sbox_key_gen dut (
    .clk_i(clk_i), .rst_i(rst_i), .key_i(key_i), .key_valid_i(key_valid_i),
    .key_ready_o(key_ready_o), .s0_o(s0_o), .s1_o(s1_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int p;
    int x;
    p = 0;
    x = int'(a);
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (x << i);
    for (int bt = 14; bt >= 8; bt--)
      if ((p >> bt) & 1) p = p ^ (32'h14D << (bt - 8));
    return p[7:0];
  endfunction

  function automatic logic [63:0] ref_rs(input logic [127:0] k);
    logic [31:0] s0, s1, c;
    logic [7:0]  m;
    s0 = 0;
    s1 = 0;
    for (int j = 0; j < 16; j++) begin
      m = k[127 - 8*j -: 8];
      c = RS_COLS[j % 8];
      for (int i = 0; i < 4; i++) begin
        if (j < 8) s0[31 - 8*i -: 8] = s0[31 - 8*i -: 8] ^ ref_mul(c[31 - 8*i -: 8], m);
        else       s1[31 - 8*i -: 8] = s1[31 - 8*i -: 8] ^ ref_mul(c[31 - 8*i -: 8], m);
      end
    end
    return {s0, s1};
  endfunction

  // Monitor: latency on out_valid rise, value compare on each output handshake
  always @(negedge clk_i) begin
    if (rst_i) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid_o && !prev_ov) begin
        if (acc_q.size() == 0) chk("unexpected_out_valid", 64'd1, 64'd0);
        else chk("latency", 64'(cyc - acc_q.pop_front()), 64'd16);
      end
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) chk("unexpected_result", 64'd1, 64'd0);
        else chk("s0_s1", {s0_o, s1_o}, exp_q.pop_front());
      end
      prev_ov = out_valid_o;
    end
  end

  int last_acc = 0;

  // Called at a negedge; returns at the negedge right after the accepting edge
  task automatic send(input logic [127:0] k, input bit hold);
    int n = 0;
    key_i = k;
    key_valid_i = 1'b1;
    while (!key_ready_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 100) begin
      chk("accept_timeout", 64'd1, 64'd0);
    end else begin
      exp_q.push_back(ref_rs(k));
      acc_q.push_back(cyc + 1);
    end
    @(negedge clk_i);
    last_acc = cyc;
    if (!hold) key_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 200) chk("drain_timeout", 64'd1, 64'd0);
    @(negedge clk_i);
  endtask

  initial begin
    logic [127:0] k;
    logic [31:0]  hs0, hs1;
    int n, prev_acc;
    rst_i = 1'b1;
    key_i = '0;
    key_valid_i = 1'b0;
    out_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("rst_key_ready", 64'(key_ready_o), 64'd1);
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_s0_s1", {s0_o, s1_o}, 64'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    send(128'h0, 1'b0); drain();
    send({8'h01, 120'h0}, 1'b0); drain();
    send({56'h0, 8'h01, 64'h0}, 1'b0); drain();
    send({64'h0, 8'h01, 56'h0}, 1'b0); drain();
    send({8'h00, 8'h02, 112'h0}, 1'b0); drain();
    chk("known_m1_02", 64'(s0_o), 64'h05AC0FAA);

    // Stall in DONE: outputs hold and a new key is refused
    out_ready_i = 1'b0;
    k = {$urandom, $urandom, $urandom, $urandom};
    send(k, 1'b0);
    n = 0;
    while (!out_valid_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    chk("stall_out_valid", 64'(out_valid_o), 64'd1);
    hs0 = s0_o;
    hs1 = s1_o;
    chk("stall_value", {hs0, hs1}, ref_rs(k));
    for (int i = 0; i < 10; i++) begin
      key_i = ~k;
      key_valid_i = i[0];
      @(negedge clk_i);
      chk("stall_hold_valid", 64'(out_valid_o), 64'd1);
      chk("stall_no_ready", 64'(key_ready_o), 64'd0);
      chk("stall_hold_s", {s0_o, s1_o}, {hs0, hs1});
    end
    key_valid_i = 1'b0;
    out_ready_i = 1'b1;
    drain();

    // Reset in the middle of CALC aborts the computation
    send({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    repeat (7) @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("abort_out_valid", 64'(out_valid_o), 64'd0);
    chk("abort_key_ready", 64'(key_ready_o), 64'd1);
    chk("abort_s0_s1", {s0_o, s1_o}, 64'd0);
    exp_q.delete();
    acc_q.delete();
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    send({8'h01, 120'h0}, 1'b0); drain();
    chk("post_abort_s0", 64'(s0_o), 64'h01A402A4);

    // Back-to-back random keys with valid and ready held high
    for (int i = 0; i < 8; i++) begin
      prev_acc = last_acc;
      send({$urandom, $urandom, $urandom, $urandom}, 1'b1);
      if (i > 0) chk("b2b_spacing", 64'(last_acc - prev_acc), 64'd18);
    end
    key_valid_i = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1, "timeout");
  end

endmodule
